// File: rtl/aprop_trace_pkg.sv
// Shared definitions for the AProp port-activity tracer: state encodings,
// default parameters and the saturating drop-counter helper.
package aprop_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_TS_WIDTH = 24;
    localparam int DEF_TIMEOUT  = 12800;
    localparam int DROP_W       = 16;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/aprop_port_tracer_if.sv
// Event read-out stream of the tracer: show-ahead head entry with valid/ready.
interface aprop_port_tracer_if #(
    parameter int WIDTH    = 32,
    parameter int TS_WIDTH = 24
);
    logic                ev_valid_out;
    logic                ev_ready_in;
    logic [WIDTH-1:0]    ev_value_out;
    logic [TS_WIDTH-1:0] ev_time_out;

    modport master (
        output ev_valid_out, ev_value_out, ev_time_out,
        input  ev_ready_in
    );

    modport slave (
        input  ev_valid_out, ev_value_out, ev_time_out,
        output ev_ready_in
    );
endinterface

// File: rtl/aprop_trace_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is only taken when a
// pop happens on the same edge.
module aprop_trace_fifo #(
    parameter int DATA_W = 56,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              empty_q, empty_d;
    logic              do_push_s, do_pop_s;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = empty_q;
    assign dout  = mem_q[rd_ptr_q];

    // Pointer, occupancy and storage update.
    always_comb begin
        do_pop_s  = pop & ~empty_q;
        do_push_s = push & (~full | do_pop_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == CW'(0));
    end

    // Storage and pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
        end
    end

endmodule

// File: rtl/aprop_port_tracer.sv
// Port-activity tracer: arms on a trigger pattern, time-stamps every masked
// port change into a FIFO and stops after a period of port silence.
module aprop_port_tracer
    import aprop_trace_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int TS_WIDTH = DEF_TS_WIDTH,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               enable_in,
    input  logic [WIDTH-1:0]   port_in,
    input  logic [WIDTH-1:0]   mask_in,
    input  logic [WIDTH-1:0]   trig_mask_in,
    input  logic [WIDTH-1:0]   trig_value_in,
    aprop_port_tracer_if.master ev,
    output logic               overflow_out,
    output logic [DROP_W-1:0]  drop_count_out,
    output logic               timeout_out,
    output logic [1:0]         state_out
);
    localparam int DATA_W = WIDTH + TS_WIDTH;
    localparam int WD_W   = $clog2(TIMEOUT) + 1;

    state_e              state_q, state_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [WIDTH-1:0]    prev_q, prev_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                overflow_q, overflow_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                timeout_q, timeout_d;

    logic                change_s, trig_s, push_req_s, clr_s, drop_s;
    logic                fifo_push_s, pop_s, full_s, empty_s;
    logic [DATA_W-1:0]   head_s;

    assign change_s = ((port_in ^ prev_q) & mask_in) != '0;
    assign trig_s   = (port_in & trig_mask_in) == trig_value_in;
    assign pop_s    = ~empty_s & ev.ev_ready_in;

    aprop_trace_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk_in),
        .rst_n (reset_in),
        .push  (fifo_push_s),
        .din   ({ts_q, port_in}),
        .pop   (pop_s),
        .full  (full_s),
        .empty (empty_s),
        .dout  (head_s)
    );

    assign ev.ev_valid_out = ~empty_s;
    assign ev.ev_value_out = head_s[WIDTH-1:0];
    assign ev.ev_time_out  = head_s[DATA_W-1:WIDTH];
    assign overflow_out    = overflow_q;
    assign drop_count_out  = drop_q;
    assign timeout_out     = timeout_q;
    assign state_out       = state_q;

    // State register together with the timestamp, watchdog and status flops.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_q    <= ST_IDLE;
            ts_q       <= '0;
            prev_q     <= '0;
            wd_q       <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            prev_q     <= prev_d;
            wd_q       <= wd_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next state and watchdog; the watchdog restarts on every capture attempt.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        if (!enable_in) begin
            state_d = ST_IDLE;
            wd_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARMED;
                    wd_d    = '0;
                end
                ST_ARMED: begin
                    if (trig_s) begin
                        state_d = ST_RUN;
                        wd_d    = '0;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_RUN: begin
                    if (change_s) begin
                        wd_d = '0;
                    end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Capture requests, overflow/drop accounting and free-running datapath.
    always_comb begin
        push_req_s = 1'b0;
        clr_s      = 1'b0;
        if (enable_in) begin
            case (state_q)
                ST_IDLE:  clr_s      = 1'b1;
                ST_ARMED: push_req_s = trig_s;
                ST_RUN:   push_req_s = change_s;
                default:  push_req_s = 1'b0;
            endcase
        end else begin
            push_req_s = 1'b0;
        end
        fifo_push_s = push_req_s & (~full_s | pop_s);
        drop_s      = push_req_s & full_s & ~pop_s;
        if (clr_s) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end else if (drop_s) begin
            overflow_d = 1'b1;
            drop_d     = sat_inc(drop_q);
        end else begin
            overflow_d = overflow_q;
            drop_d     = drop_q;
        end
        timeout_d = (state_d == ST_DONE);
        ts_d      = ts_q + TS_WIDTH'(1);
        prev_d    = port_in;
    end

endmodule

// File: tb/tb_aprop_port_tracer.sv
// Scoreboard bench: a cycle-level reference model fills the expected-event
// queue; a negedge monitor compares head, status and state against it.
module tb_aprop_port_tracer;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int TW = 10;
    localparam int TO = 100;

    logic         clk = 1'b0;
    logic         reset_in, enable_in;
    logic [W-1:0] port_in, mask_in, trig_mask_in, trig_value_in;
    logic [W-1:0] cur_port;
    logic [15:0]  drop_count_out;
    logic         overflow_out, timeout_out;
    logic [1:0]   state_out;

    aprop_port_tracer_if #(.WIDTH(W), .TS_WIDTH(TW)) ev_if ();

    aprop_port_tracer #(.WIDTH(W), .DEPTH(D), .TS_WIDTH(TW), .TIMEOUT(TO)) dut (
        .clk_in         (clk),
        .reset_in       (reset_in),
        .enable_in      (enable_in),
        .port_in        (port_in),
        .mask_in        (mask_in),
        .trig_mask_in   (trig_mask_in),
        .trig_value_in  (trig_value_in),
        .ev             (ev_if),
        .overflow_out   (overflow_out),
        .drop_count_out (drop_count_out),
        .timeout_out    (timeout_out),
        .state_out      (state_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state, all in terms of cycles and queue contents.
    logic [TW+W-1:0] exp_q[$];
    int          m_state = 0;
    int          m_cyc = 0;
    int          m_last_push = 0;
    logic        m_ovf = 1'b0;
    int          m_drops = 0;
    logic [W-1:0] m_prev = '0;
    bit          model_ok = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (!reset_in) begin
                m_state = 0; m_cyc = 0; m_ovf = 1'b0; m_drops = 0;
                m_prev = '0; exp_q.delete(); model_ok = 1'b1;
            end else begin
                bit do_push;
                logic [TW-1:0] ts;
                do_push = 1'b0;
                ts = TW'(m_cyc);
                if (!enable_in) m_state = 0;
                else if (m_state == 0) begin
                    m_state = 1; m_ovf = 1'b0; m_drops = 0;
                end else if (m_state == 1) begin
                    if ((port_in & trig_mask_in) == trig_value_in) begin
                        do_push = 1'b1; m_state = 2;
                    end
                end else if (m_state == 2) begin
                    if (((port_in ^ m_prev) & mask_in) != 0) do_push = 1'b1;
                    else if (m_cyc - m_last_push == TO) m_state = 3;
                end
                if (do_push) begin
                    m_last_push = m_cyc;
                    if (exp_q.size() < D) exp_q.push_back({ts, port_in});
                    else begin
                        m_ovf = 1'b1;
                        if (m_drops < 65535) m_drops++;
                    end
                end
                m_prev = port_in;
                m_cyc++;
            end
        end
    end

    // Monitor: compare outputs mid-cycle and retire the head on a handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                check("ev_valid", 64'(ev_if.ev_valid_out), 64'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    check("ev_value", 64'(ev_if.ev_value_out), 64'(exp_q[0][W-1:0]));
                    check("ev_time", 64'(ev_if.ev_time_out), 64'(exp_q[0][TW+W-1:W]));
                    if (ev_if.ev_ready_in) void'(exp_q.pop_front());
                end
                check("state", 64'(state_out), 64'(m_state));
                check("timeout", 64'(timeout_out), 64'(m_state == 3));
                check("overflow", 64'(overflow_out), 64'(m_ovf));
                check("drop_count", 64'(drop_count_out), 64'(m_drops));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setp(input logic [W-1:0] p);
        port_in = p;
        tick();
    endtask

    initial begin
        int k;
        reset_in = 1'b0; enable_in = 1'b0; port_in = '0; mask_in = '0;
        trig_mask_in = '0; trig_value_in = '0; ev_if.ev_ready_in = 1'b0;
        tick(); tick();
        check("reset_valid", 64'(ev_if.ev_valid_out), 64'd0);
        check("reset_state", 64'(state_out), 64'd0);

        // Trigger on low byte 0x5A after ten idle-port cycles.
        reset_in = 1'b1; enable_in = 1'b1;
        trig_mask_in = 32'h0000_00FF; trig_value_in = 32'h0000_005A;
        for (int i = 0; i < 10; i++) setp(32'h0);
        check("pre_trig_valid", 64'(ev_if.ev_valid_out), 64'd0);
        setp(32'h0000_005A);
        check("first_ev_value", 64'(ev_if.ev_value_out), 64'h5A);
        check("first_ev_time", 64'(ev_if.ev_time_out), 64'd10);

        // Unmasked bit 8 then masked bit 2.
        mask_in = 32'h0000_000F; ev_if.ev_ready_in = 1'b1;
        setp(32'h0000_015A);
        setp(32'h0000_015E);
        for (int i = 0; i < 3; i++) tick();

        // Six changes into a 4-deep FIFO with no consumer.
        ev_if.ev_ready_in = 1'b0;
        for (int i = 0; i < 6; i++) setp(32'h0000_0150 + 32'(i));
        check("ovf_flag", 64'(overflow_out), 64'd1);
        check("ovf_drops", 64'(drop_count_out), 64'd2);

        // Full FIFO with simultaneous pop: new entry accepted.
        ev_if.ev_ready_in = 1'b1;
        setp(32'h0000_0156);
        check("full_pop_drops", 64'(drop_count_out), 64'd2);

        // Watchdog measured from the last push.
        k = 0;
        while (state_out != 2'd3 && k < 200) begin
            tick();
            k++;
        end
        check("wd_cycles", 64'(k), 64'd100);
        check("wd_timeout", 64'(timeout_out), 64'd1);

        enable_in = 1'b0; tick();
        check("disable_idle", 64'(state_out), 64'd0);
        enable_in = 1'b1; tick();
        check("rearm_ovf", 64'(overflow_out), 64'd0);
        check("rearm_drops", 64'(drop_count_out), 64'd0);

        // Reset while three events are queued.
        trig_mask_in = '0; trig_value_in = '0;
        tick(); tick();
        ev_if.ev_ready_in = 1'b0;
        setp(32'h0000_0157); setp(32'h0000_0158); setp(32'h0000_0159);
        reset_in = 1'b0; tick();
        check("rst_mid_valid", 64'(ev_if.ev_valid_out), 64'd0);
        check("rst_mid_state", 64'(state_out), 64'd0);
        reset_in = 1'b1; tick(); tick();
        check("rst_ts_restart", 64'(ev_if.ev_time_out), 64'd1);

        // Randomised traffic; long reset-free stretches wrap the timestamp.
        cur_port = 32'h0000_0159;
        for (int i = 0; i < 3000; i++) begin
            reset_in  = ($urandom_range(0, 999) != 0);
            enable_in = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 9) == 0) cur_port = cur_port ^ (32'h1 << $urandom_range(0, 31));
            if ($urandom_range(0, 99) == 0) mask_in = $urandom() & $urandom();
            if ($urandom_range(0, 99) == 0) begin
                trig_mask_in  = 32'($urandom_range(0, 3));
                trig_value_in = 32'($urandom_range(0, 3)) & trig_mask_in;
            end
            ev_if.ev_ready_in = ($urandom_range(0, 3) == 0);
            setp(cur_port);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aprop_port_tracer.md
Name: aprop_port_tracer

Overview:
- Synthesizable, parametrised port-activity tracer for the AProp simulation and FPGA bring-up flow.
- Watches a cog or prop I/O port, for example port_a, and time-stamps every masked change into a FIFO.
- Supports trigger arming and a no-activity watchdog, so benches and on-chip debug end on port silence rather than a fixed run time.
- Sits beside AProp, on the same clk_in; read out through a valid/ready event stream.

Parameters:
- WIDTH, 32: monitored port width.
- DEPTH, 16: event FIFO entries; power of two, at least 2.
- TS_WIDTH, 24: timestamp counter width.
- TIMEOUT, 12800: RUN-state cycles without a captured change before DONE.

Ports:
- clk_in  in  1  system clock.
- reset_in  in  1  synchronous, active-low reset.
- enable_in  in  1  arm/run request; low forces IDLE.
- port_in  in  WIDTH  monitored port.
- mask_in  in  WIDTH  bits whose change creates an event.
- trig_mask_in  in  WIDTH  trigger compare mask.
- trig_value_in  in  WIDTH  trigger compare value.
- ev_valid_out  out  1  FIFO head valid.
- ev_ready_in  in  1  consumer accepts head.
- ev_value_out  out  WIDTH  port value of head event.
- ev_time_out  out  TS_WIDTH  timestamp of head event.
- overflow_out  out  1  sticky: an event was dropped.
- drop_count_out  out  16  dropped events, saturating at 16'hFFFF.
- timeout_out  out  1  high while in DONE.
- state_out  out  2  current state: IDLE=0, ARMED=1, RUN=2, DONE=3.

Behaviour:
- Reset (reset_in=0 at a clk_in edge):
  - state IDLE; FIFO emptied; prev_port and timestamp set to 0; watchdog cleared.
  - All outputs 0: ev_valid, ev_value, ev_time, overflow, drop_count, timeout, state.
- Timestamp counter: free-running from reset, increments every cycle, wraps modulo 2^TS_WIDTH with no event on wrap.
- prev_port register: loads port_in every cycle in every state.
- change = ((port_in ^ prev_port) & mask_in) != 0.
- State machine, evaluated each edge; enable_in=0 has priority and sends any state to IDLE next cycle:
  - IDLE: when enable_in=1, go to ARMED, clear overflow_out and drop_count_out. FIFO is not flushed.
  - ARMED: trigger when (port_in & trig_mask_in) == trig_value_in (trig_mask_in=0 triggers immediately). On trigger, go to RUN and push {timestamp, port_in} unconditionally as the first event.
  - RUN: push {timestamp, port_in} on every change. Watchdog counter resets to 0 on each push attempt, otherwise increments. Reaching TIMEOUT-1 goes to DONE next cycle.
  - DONE: no capture; timeout_out=1; stays until enable_in=0.
- Latency: an event sampled at edge t appears at the FIFO head no earlier than edge t+1. ev_time_out is the counter value at edge t.
- FIFO:
  - Show-ahead; ev_value_out and ev_time_out are stable while ev_valid_out=1 and ev_ready_in=0.
  - Pop on ev_valid_out & ev_ready_in.
  - Full with simultaneous pop: push accepted, no drop.
  - Full without pop: entry dropped, overflow_out set, drop_count_out incremented (saturating).
  - Empty: ev_valid_out=0; ev_ready_in ignored.
- Draining continues in every state, including IDLE and DONE.
- Reset mid-capture discards all FIFO contents.
- A change on an unmasked bit never creates an event and never resets the watchdog.

Decomposition:
- Package aprop_trace_pkg holds:
  - state encodings: ST_IDLE, ST_ARMED, ST_RUN, ST_DONE;
  - default parameter constants;
  - the drop-counter width, 16.
- Sub-module aprop_trace_fifo: synchronous FIFO, parameters DATA_W=WIDTH+TS_WIDTH and DEPTH, with push/pop/full/empty.
- Tracer top holds the FSM, timestamp, watchdog and the overflow/drop logic.

Test Plan:
- Trigger and first event: reset, enable_in=1, trig_mask=32'hFF, trig_value=8'h5A, drive port 0x00 for 10 cycles then 0x5A -> ARMED to RUN; first event value 0x5A with that cycle's timestamp; no event before it.
- Masked changes: mask_in=32'h0000_000F in RUN; toggle bit 8, then bit 2 -> exactly one event for the bit-2 change; ev_time_out equals its sample cycle.
- Overflow: DEPTH=4, ev_ready_in=0, 6 distinct changes -> 4 entries held, overflow_out=1, drop_count_out=2. Then drain -> the 4 oldest values come out in order.
- Full plus simultaneous pop: FIFO full, ev_ready_in=1 on the same cycle as a new change -> no drop, count stays at 4.
- Watchdog: TIMEOUT=100, no masked change after one event -> state_out=3 and timeout_out=1 exactly 100 cycles after the last push. Then enable_in=0 -> IDLE. Re-enable -> overflow_out and drop_count_out cleared.
- Reset mid-run: 3 events queued, reset_in=0 for one cycle -> ev_valid_out=0, state_out=0, timestamp restarts at 0.
